// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator frequency counter.
package ro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Header byte layout: {ovf, 3'b000, chan[3:0]}
  localparam int HDR_OVF_BIT = 7;
  localparam int HDR_CH_LSB  = 0;
  localparam int HDR_CH_W    = 4;

  // Number of payload bytes needed to carry a CNT_W-bit count.
  function automatic int nbytes(input int cnt_w);
    return (cnt_w + 7) / 8;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Per-channel synchroniser and rising-edge detector for one oscillator input.
// History runs every cycle so a window never sees a stale edge at its start.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ro_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  // Metastability chain plus one history flop behind it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ro_in};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/ro_freq_counter.sv
// Multi-channel RO edge counter: counts rising edges of the selected
// oscillator over a window of clk cycles, then streams a header byte plus
// the count (MSB first) on a valid/ready byte interface.
module ro_freq_counter
  import ro_pkg::*;
#(
  parameter  int N_CH        = 2,
  parameter  int CNT_W       = 24,
  parameter  int WIN_W       = 20,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_CH-1:0]  ro_in,
  input  logic             start,
  input  logic [CH_W-1:0]  chan_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic             continuous,
  output logic             busy,
  output logic             done,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready
);

  localparam int NB      = nbytes(CNT_W);
  localparam int FRAME_W = 8 * NB;
  localparam int IDX_W   = 3;

  logic [N_CH-1:0] rise;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .ro_in   (ro_in[i]),
      .rise    (rise[i])
    );
  end

  state_t             state;
  logic [CH_W-1:0]    chan;
  logic [WIN_W-1:0]   win;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic [IDX_W-1:0]   byte_idx;

  logic               hit;
  logic               cnt_full;
  logic               ovf_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CH_W-1:0]    chan_new;
  logic [FRAME_W-1:0] cnt_ext;
  logic [7:0]         next_byte;

  function automatic logic [7:0] header(input logic o, input logic [CH_W-1:0] c);
    logic [7:0] h;
    h = '0;
    h[HDR_OVF_BIT] = o;
    h[HDR_CH_LSB +: HDR_CH_W] = HDR_CH_W'(c);
    return h;
  endfunction

  // Saturating count, sticky overflow, channel clamp and payload byte select.
  always_comb begin
    hit       = (state == COUNT) && rise[chan];
    cnt_full  = &cnt;
    cnt_nxt   = (hit && !cnt_full) ? cnt + CNT_W'(1) : cnt;
    ovf_nxt   = ovf | (hit & cnt_full);
    chan_new  = (int'(chan_sel) < N_CH) ? chan_sel : '0;
    cnt_ext   = FRAME_W'(cnt);
    next_byte = '0;
    // byte_idx k presents payload byte k+1, MSB first
    for (int k = 1; k <= NB; k++)
      if (int'(byte_idx) + 1 == k) next_byte = cnt_ext[8*(NB-k) +: 8];
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      chan     <= '0;
      win      <= '0;
      win_cnt  <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            chan     <= chan_new;
            win      <= win_len;
            cnt      <= '0;
            ovf      <= 1'b0;
            byte_idx <= '0;
            busy     <= 1'b1;
            if (win_len == '0) begin
              state    <= SEND;
              tx_valid <= 1'b1;
              tx_data  <= header(1'b0, chan_new);
            end else begin
              state   <= COUNT;
              win_cnt <= win_len;
            end
          end
        end
        COUNT: begin
          cnt     <= cnt_nxt;
          ovf     <= ovf_nxt;
          win_cnt <= win_cnt - WIN_W'(1);
          if (win_cnt == WIN_W'(1)) begin
            state    <= SEND;
            byte_idx <= '0;
            tx_valid <= 1'b1;
            tx_data  <= header(ovf_nxt, chan);
          end
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            if (byte_idx == IDX_W'(NB)) begin
              done     <= 1'b1;
              tx_valid <= 1'b0;
              byte_idx <= '0;
              if (continuous) begin
                cnt <= '0;
                ovf <= 1'b0;
                if (win == '0) begin
                  // zero-length window: next header goes out immediately
                  tx_valid <= 1'b1;
                  tx_data  <= header(1'b0, chan);
                end else begin
                  state   <= COUNT;
                  win_cnt <= win;
                end
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              tx_data  <= next_byte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: a frame-level reference model
// predicts every byte from the logged oscillator waveforms, a per-cycle
// compare process checks the DUT, and directed frames pin literal values.
module tb_ro_freq_counter;

  localparam int N_CH  = 3;
  localparam int CNT_W = 10;
  localparam int WIN_W = 13;
  localparam int SYNC  = 2;
  localparam int CH_W  = 2;
  localparam int NB    = (CNT_W + 7) / 8;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int LOGN  = 40000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N_CH-1:0]  ro_in = '0;
  logic             start;
  logic [CH_W-1:0]  chan_sel;
  logic [WIN_W-1:0] win_len;
  logic             continuous;
  logic             busy, done, tx_valid, tx_ready;
  logic [7:0]       tx_data;

  ro_freq_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .ro_in(ro_in), .start(start), .chan_sel(chan_sel),
    .win_len(win_len), .continuous(continuous), .busy(busy), .done(done),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Oscillator generators: half-period in clk cycles, 0 = held low.
  int hp [N_CH];
  int ph [N_CH];
  initial for (int i = 0; i < N_CH; i++) begin hp[i] = 0; ph[i] = 0; end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N_CH; i++) begin
      if (hp[i] == 0) ro_in[i] = 1'b0;
      else begin
        ph[i]++;
        if (ph[i] >= hp[i]) begin ph[i] = 0; ro_in[i] = ~ro_in[i]; end
      end
    end
  end

  // ---------------- reference model ----------------
  bit         ro_log [N_CH][LOGN];
  int         cyc = 0;
  int         last_rst = -1;
  bit         m_active = 0;
  int         m_chan = 0, m_win = 0, present = -1;
  byte        q[$];
  bit         e_valid = 0, e_done = 0, e_busy = 0;
  logic [7:0] e_data = '0;

  // Input as seen by the edge detector: samples at or before a reset are gone.
  function automatic int ro_v(int ch, int k);
    if (k < 0 || k <= last_rst) return 0;
    return int'(ro_log[ch][k]);
  endfunction

  // A rising edge of the sampled input shows up SYNC cycles later.
  function automatic int rise_at(int ch, int c);
    return (ro_v(ch, c - SYNC) == 1 && ro_v(ch, c - SYNC - 1) == 0) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    bit n_done;
    n_done = 0;
    for (int i = 0; i < N_CH; i++) ro_log[i][cyc] = ro_in[i];
    if (!reset_n) begin
      m_active = 0; q.delete(); present = -1;
      e_valid = 0; e_data = '0; e_done = 0; e_busy = 0;
      last_rst = cyc;
    end else begin
      if (e_valid && tx_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          n_done = 1;
          if (continuous) present = cyc + 1 + m_win;
          else m_active = 0;
        end
      end else if (!m_active && start) begin
        m_active = 1;
        m_chan   = (int'(chan_sel) >= N_CH) ? 0 : int'(chan_sel);
        m_win    = int'(win_len);
        present  = cyc + 1 + m_win;
      end
      if (m_active && present == cyc + 1) begin
        int r, cv;
        bit o;
        r = 0;
        for (int c = cyc + 1 - m_win; c <= cyc; c++) r += rise_at(m_chan, c);
        o  = (r > MAXC);
        cv = o ? MAXC : r;
        q.push_back({o, 3'b000, 4'(m_chan)});
        for (int k = NB - 1; k >= 0; k--) q.push_back(8'(cv >> (8 * k)));
      end
      e_done  = n_done;
      e_busy  = m_active;
      e_valid = (q.size() > 0);
      if (e_valid) e_data = q[0];
    end
    cyc++;
  end

  // ---------------- compare + capture ----------------
  byte got[$];
  int  n_done_seen = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("tx_valid", 32'(tx_valid), 32'(e_valid));
      if (e_valid) chk("tx_data", 32'(tx_data), 32'(e_data));
      if (reset_n && tx_valid && tx_ready) got.push_back(tx_data);
      if (done) n_done_seen++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 20000) begin tick(); n++; end
    if (busy) begin n_err++; $display("FAIL %s: busy stuck high after %0d cycles", nm, n); end
    tick();
  endtask

  task automatic launch(input int ch, input int win, output int lat);
    got.delete();
    n_done_seen = 0;
    chan_sel = CH_W'(ch);
    win_len  = WIN_W'(win);
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!tx_valid && lat < 10000) begin tick(); lat++; end
  endtask

  task automatic chk_frame(input string nm, input int off, input byte b0, input byte b1, input byte b2);
    byte exp3 [3];
    exp3 = '{b0, b1, b2};
    for (int i = 0; i < 3; i++)
      chk(nm, (off + i < got.size()) ? 32'(got[off + i]) : 32'hdead, 32'(exp3[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    reset_n = 1'b0; start = 1'b0; chan_sel = '0; win_len = '0;
    continuous = 1'b0; tx_ready = 1'b1;
    tick();
    chk_on = 1;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_done", 32'(done), 0);

    hp[0] = 2;  // period 4 cycles on ch0
    repeat (20) tick();

    // 100-cycle window, ch0: 25 edges, first byte 101 cycles after start
    launch(0, 100, lat);
    chk("lat_win100", 32'(lat), 101);
    wait_idle("d1");
    chk_frame("frame_d1", 0, 8'h00, 8'h00, 8'h19);
    chk("done_d1", 32'(n_done_seen), 1);

    // out-of-range select falls back to ch0; ch1 activity ignored
    hp[1] = 3;
    repeat (10) tick();
    launch(3, 60, lat);
    wait_idle("d2");
    chk_frame("frame_oor", 0, 8'h00, 8'h00, 8'h0f);

    // idle channel while others toggle
    launch(2, 60, lat);
    wait_idle("d3");
    chk_frame("frame_idle", 0, 8'h02, 8'h00, 8'h00);

    // zero-length window
    launch(1, 0, lat);
    chk("lat_win0", 32'(lat), 1);
    wait_idle("d4");
    chk_frame("frame_win0", 0, 8'h01, 8'h00, 8'h00);

    // backpressure on the second byte: 275 = 0x113
    tx_ready = 1'b0;
    launch(0, 1100, lat);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(tx_valid), 1);
      chk("bp_data", 32'(tx_data), 32'h01);
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("d5");
    chk_frame("frame_bp", 0, 8'h00, 8'h01, 8'h13);

    // saturation: 1050 edges into a 10-bit counter
    launch(0, 4200, lat);
    wait_idle("d6");
    chk_frame("frame_sat", 0, 8'h80, 8'h03, 8'hff);

    // continuous: two identical frames, then drop continuous
    continuous = 1'b1;
    launch(0, 100, lat);
    lat = 0;
    while (n_done_seen == 0 && lat < 1000) begin tick(); lat++; end
    repeat (20) tick();
    continuous = 1'b0;
    wait_idle("d7");
    chk("cont_bytes", 32'(got.size()), 6);
    chk_frame("frame_cont0", 0, 8'h00, 8'h00, 8'h19);
    chk_frame("frame_cont1", 3, 8'h00, 8'h00, 8'h19);
    chk("cont_dones", 32'(n_done_seen), 2);

    // reset mid-COUNT aborts cleanly
    chan_sel = '0; win_len = WIN_W'(200); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(tx_valid), 0);
    chk("abort_data", 32'(tx_data), 0);
    repeat (10) tick();

    // start mid-SEND is ignored
    tx_ready = 1'b0;
    launch(0, 48, lat);
    chan_sel = 2'd1; win_len = WIN_W'(5); start = 1'b1;
    tick();
    start = 1'b0;
    tx_ready = 1'b1;
    wait_idle("d8");
    chk_frame("frame_midsend", 0, 8'h00, 8'h00, 8'h0c);

    // randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      start    = ($urandom % 25) == 0;
      chan_sel = CH_W'($urandom % 4);
      win_len  = WIN_W'($urandom % 160);
      tx_ready = ($urandom % 4) != 0;
      if (($urandom % 60) == 0) continuous = ~continuous;
      reset_n  = ($urandom % 2000) != 0;
      if (($urandom % 300) == 0) begin
        int c, v;
        c = int'($urandom % N_CH);
        v = int'($urandom % 6);
        hp[c] = (v == 0) ? 0 : v + 1;
      end
      tick();
    end
    start = 1'b0; continuous = 1'b0; reset_n = 1'b1; tx_ready = 1'b1;
    wait_idle("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Parametrised multi-channel ring-oscillator edge counter for the RO temperature sensor.
- It selects one of N_CH oscillator outputs and counts its rising edges over a programmable window of system-clock cycles.
- The result is emitted as a byte frame on a valid/ready stream that feeds the UART transmitter.
- Adds over the previous generation: arbitrary channel count, counter and window widths, continuous (free-running) mode, a saturation flag and a tx backpressure handshake.

Parameters:
- N_CH, 2, number of oscillator inputs (1..16).
- CNT_W, 24, edge-counter width in bits (8..32).
- WIN_W, 20, width of the window-length input.
- SYNC_STAGES, 2, synchroniser depth per oscillator input (≥2).

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  reset, synchronous and active-low.
- ro_in  in  N_CH  asynchronous oscillator outputs; each must run below f_clk/2.
- start  in  1  single-cycle request to begin a measurement.
- chan_sel  in  CH_W  channel index; CH_W = max(1, clog2(N_CH)).
- win_len  in  WIN_W  window length in clk cycles.
- continuous  in  1  when high, re-arms automatically after each frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last byte of a frame is accepted.
- tx_valid  out  1  byte available.
- tx_data  out  8  frame byte.
- tx_ready  in  1  downstream accepts the byte when tx_valid && tx_ready.

Behaviour:
- Reset (reset_n low at a clk edge): FSM goes to IDLE; counter, ovf, byte index and synchroniser/edge history are cleared; busy=0, done=0, tx_valid=0, tx_data=0x00. Reset mid-operation aborts with no partial byte.
- Input conditioning: every ro_in bit passes through a SYNC_STAGES flop chain plus one history flop, updated every cycle in all states. edge = sync & ~hist. Because history runs continuously, there is no false edge at window start.
- FSM states: IDLE, COUNT, SEND.
- IDLE:
  - If start=1: latch chan_sel and win_len, clear counter and ovf, load window counter with win_len, go to COUNT.
  - Out-of-range chan_sel (≥N_CH) latches as channel 0.
- COUNT:
  - Runs exactly win_len cycles; a cycle counts only if the selected channel's edge is high.
  - The counter saturates at all-ones; an edge arriving at all-ones sets ovf (sticky for the frame).
  - win_len=0: COUNT lasts 0 cycles, FSM goes straight to SEND with count 0.
- SEND frame: NB+1 bytes, NB = ceil(CNT_W/8).
  - Byte 0 (header) = {ovf, 3'b000, chan[3:0]}.
  - Then the count, zero-extended to 8·NB bits, MSB first.
- Latency: start in cycle t → COUNT in t+1 … t+win_len → tx_valid asserted in cycle t+1+win_len with the header byte.
- tx handshake:
  - tx_valid and tx_data hold stable until accepted.
  - After a transfer, the next byte is presented in the following cycle; there are no bubbles while tx_ready stays high.
  - tx_valid never drops without a transfer except on reset.
- End of frame:
  - On acceptance of the last byte, done pulses for 1 cycle.
  - If continuous=1 at that cycle, go to COUNT with the same latched channel and window (counter cleared); otherwise go to IDLE.
- start while busy is ignored. Changes to chan_sel or win_len while busy have no effect until the next start.
- Clearing continuous mid-frame: the current frame completes, then the FSM returns to IDLE.

Decomposition:
- Shared package ro_pkg holds:
  - state enum {IDLE, COUNT, SEND};
  - header bit layout constants (HDR_OVF_BIT=7, HDR_CH_LSB=0, HDR_CH_W=4);
  - function nbytes(CNT_W).
- One natural sub-module: ro_edge_sync (per-channel synchroniser plus rising-edge detector, parametrised by SYNC_STAGES), instantiated N_CH times.

Test Plan (clk period 10 ns):
- Default params, ch0 RO period 100 ns, start with chan_sel=0, win_len=1000, tx_ready=1 → first tx_valid 1001 cycles after start; bytes 0x00,0x00,0x00,0x64 (count 100 ±1); done pulses once; busy falls the cycle after done.
- ch1 RO period 40 ns, ch0 idle, chan_sel=1, win_len=250 → header 0x01, count 0x00003E..0x000040; ch0 activity contributes nothing.
- CNT_W=8 build, RO period 40 ns, win_len=2000 → header 0x80, count byte 0xFF.
- Backpressure: tx_ready held low 5 cycles on byte 2 → tx_valid=1 and tx_data unchanged for those cycles; the remaining bytes follow in order with no loss.
- continuous=1, win_len=100 → two back-to-back frames with identical header; second COUNT starts the cycle after the first done. Drop continuous during the second COUNT → returns to IDLE after the second frame.
- reset_n low for 1 cycle mid-COUNT, and start pulsed mid-SEND → reset clears busy/tx_valid next cycle with no further bytes; the mid-SEND start is ignored and the frame is unchanged.
